// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
//
// Backing store on the memory side of the data cache's block refill and
// writeback path. One 128-bit block access (read = refill, write = writeback)
// is serviced at a time, with a fixed access latency. Completion is flagged by
// a one-cycle ready pulse.
//
// Parameters
//   LATENCY     edges from request acceptance to commit (1..255)
//   DEPTH_BITS  log2 of the number of 128-bit blocks held
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high; returns control to idle
//   req_read     in   level request: read block at req_addr
//   req_write    in   level request: write write_block to req_addr
//   req_addr     in   block address (byte address [31:4]); low DEPTH_BITS used
//   write_block  in   writeback data, word 0 in [31:0]
//   read_block   out  refill data, held until the next read commit
//   ready        out  one-cycle completion pulse
//   busy         out  high while a request is in flight or completing
// -----------------------------------------------------------------------------
module main_memory #(
   parameter int LATENCY    = 5,
   parameter int DEPTH_BITS = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_read,
   input  logic         req_write,
   input  logic [27:0]  req_addr,
   input  logic [127:0] write_block,
   output logic [127:0] read_block,
   output logic         ready,
   output logic         busy
);

   localparam int         MEM_WORDS = 1 << DEPTH_BITS;
   localparam logic [7:0] CNT_LOAD  = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    wr_q, wr_d;
   logic [DEPTH_BITS-1:0]   addr_q, addr_d;
   logic [127:0]            data_q, data_d;
   logic [127:0]            rblk_q, rblk_d;
   logic                    ready_q, ready_d;
   logic                    busy_q, busy_d;

   // Block storage. Not touched by reset; contents survive a controller reset.
   logic [127:0]            mem_q [MEM_WORDS];

   logic                    commit;

   // Upper address bits alias onto the stored blocks and are deliberately
   // dropped.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^req_addr[27:DEPTH_BITS];

   // The access lands on the edge where the BUSY countdown has reached zero.
   assign commit = (state_q == BUSY) && (cnt_q == 8'd0);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rblk_d  = rblk_q;

      case (state_q)
         IDLE: begin
            // Write wins when both are raised; the held read is taken later.
            if (req_write || req_read) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
               wr_d    = req_write;
               addr_d  = req_addr[DEPTH_BITS-1:0];
               data_d  = write_block;
            end
         end
         BUSY: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = DONE;
               if (!wr_q) begin
                  rblk_d = mem_q[addr_q];
               end
            end
         end
         DONE: begin
            // Requests here are ignored so the requester can drop on ready.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
   end

   // Control state and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         rblk_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rblk_q  <= rblk_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
      // Captured request fields only matter once BUSY is entered, which
      // reset prevents, so they need no reset of their own.
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
   end

   // Array write port; a reset on the commit edge aborts the write.
   always_ff @(posedge clock) begin
      if (!reset && commit && wr_q) begin
         mem_q[addr_q] <= data_q;
      end
   end

   assign read_block = rblk_q;
   assign ready      = ready_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

   localparam int LAT = 5;

   logic         clock = 1'b0;
   logic         reset = 1'b1;

   logic         req_read = 1'b0, req_write = 1'b0;
   logic [27:0]  req_addr = '0;
   logic [127:0] write_block = '0;
   logic [127:0] read_block;
   logic         ready, busy;

   logic         req_read1 = 1'b0, req_write1 = 1'b0;
   logic [27:0]  req_addr1 = '0;
   logic [127:0] write_block1 = '0;
   logic [127:0] read_block1;
   logic         ready1, busy1;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model of the LATENCY=5 instance
   logic [127:0] ref_mem [256];
   logic [127:0] ref_rb;

   always #5 clock = ~clock;

   main_memory #(.LATENCY(LAT), .DEPTH_BITS(8)) dut (
      .clock(clock), .reset(reset),
      .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .write_block(write_block),
      .read_block(read_block), .ready(ready), .busy(busy)
   );

   main_memory #(.LATENCY(1), .DEPTH_BITS(8)) dut1 (
      .clock(clock), .reset(reset),
      .req_read(req_read1), .req_write(req_write1),
      .req_addr(req_addr1), .write_block(write_block1),
      .read_block(read_block1), .ready(ready1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One complete access on the LATENCY=5 instance; inputs are scrambled
   // right after acceptance to confirm they are captured.
   task automatic access(input bit wr, input logic [27:0] a, input logic [127:0] d,
                         input string tag);
      int  n, bcnt;
      bit  seen;
      logic [127:0] exp_rb;
      exp_rb = wr ? ref_rb : ref_mem[a[7:0]];
      @(negedge clock);
      req_write = wr; req_read = !wr; req_addr = a; write_block = d;
      @(posedge clock); #1;
      req_write = 1'b0; req_read = 1'b0;
      req_addr = 28'($urandom()); write_block = rnd128();
      bcnt = busy ? 1 : 0; n = 0; seen = 0;
      while (!seen && n < 300) begin
         @(posedge clock); #1;
         n++;
         if (busy) bcnt++;
         if (ready) seen = 1;
      end
      chk({tag, ":latency"}, n, LAT);
      chk({tag, ":data"}, read_block, exp_rb);
      @(posedge clock); #1;
      chk({tag, ":ready_pulse"}, ready, 1'b0);
      chk({tag, ":busy_cycles"}, bcnt, LAT + 1);
      if (wr) ref_mem[a[7:0]] = d;
      else    ref_rb = exp_rb;
   endtask

   task automatic write1(input logic [27:0] a, input logic [127:0] d);
      int n;
      @(negedge clock);
      req_write1 = 1'b1; req_addr1 = a; write_block1 = d;
      @(posedge clock); #1;
      req_write1 = 1'b0;
      n = 0;
      while (!ready1 && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("lat1:write_latency", n, 1);
      @(posedge clock); #1;
   endtask

   initial begin : stim
      int n1, n2;
      logic [127:0] x_blk, y_blk;
      logic [4:0]   rdy_seen;
      logic [127:0] rb_seen [5];

      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      ref_rb = '0;

      // Reset for two cycles, then release
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("reset:ready", ready, 1'b0);
      chk("reset:busy", busy, 1'b0);
      chk("reset:read_block", read_block, '0);
      chk("reset:ready1", ready1, 1'b0);
      chk("reset:read_block1", read_block1, '0);

      access(1'b0, 28'h0000003, '0, "rd3");

      // Write then read back
      access(1'b1, 28'h0000012, 128'hDEADBEEF_00000003_00000002_00000001, "wr12");
      access(1'b0, 28'h0000012, '0, "rd12");

      // Both requests together: write first, held read follows
      @(negedge clock);
      req_write = 1'b1; req_read = 1'b1; req_addr = 28'h05; write_block = {16{8'hA5}};
      @(posedge clock); #1;
      n1 = 0;
      while (!ready && n1 < 300) begin @(posedge clock); #1; n1++; end
      chk("prio:write_latency", n1, LAT);
      chk("prio:rb_untouched_by_write", read_block, ref_rb);
      req_write = 1'b0;
      n2 = 0;
      @(posedge clock); #1; n2++;
      chk("prio:busy_gap", busy, 1'b0);
      while (!ready && n2 < 300) begin @(posedge clock); #1; n2++; end
      chk("prio:read_ready_gap", n2, LAT + 2);
      chk("prio:read_data", read_block, {16{8'hA5}});
      req_read = 1'b0;
      ref_mem[5] = {16{8'hA5}};
      ref_rb = {16{8'hA5}};
      @(posedge clock); #1;

      // Reset two edges into a write
      @(negedge clock);
      req_write = 1'b1; req_addr = 28'h07; write_block = {32{4'h1}};
      @(posedge clock); #1;
      req_write = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rstmid:ready", ready, 1'b0);
      chk("rstmid:busy", busy, 1'b0);
      chk("rstmid:read_block", read_block, '0);
      ref_rb = '0;
      @(negedge clock);
      reset = 1'b0;
      access(1'b0, 28'h0000007, '0, "rstmid_rd7");

      // Aliasing above DEPTH_BITS and capture at acceptance
      access(1'b1, 28'h0000100, {8{16'hCAFE}}, "wr100");
      access(1'b0, 28'h0000000, '0, "rd0_alias");
      chk("alias:value", read_block, {8{16'hCAFE}});

      // Randomized traffic against the model
      for (int t = 0; t < 40; t++) begin
         logic [27:0] a;
         a = (28'($urandom()) & 28'hFFFFF00) | 28'($urandom_range(0, 15));
         access(1'($urandom_range(0, 1)), a, rnd128(), $sformatf("rand%0d", t));
      end

      // LATENCY=1 instance: back-to-back reads with the request held
      x_blk = rnd128();
      y_blk = rnd128();
      write1(28'h21, x_blk);
      write1(28'h3A, y_blk);
      @(negedge clock);
      req_read1 = 1'b1; req_addr1 = 28'h21;
      @(posedge clock); #1;
      req_addr1 = 28'h3A;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         rdy_seen[i] = ready1;
         rb_seen[i]  = read_block1;
      end
      req_read1 = 1'b0;
      chk("lat1:ready_pattern", rdy_seen, 5'b01001);
      chk("lat1:first_data", rb_seen[0], x_blk);
      chk("lat1:hold_data", rb_seen[2], x_blk);
      chk("lat1:second_data", rb_seen[3], y_blk);
      @(posedge clock); #1;
      chk("lat1:idle_after", busy1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "timeout");
   end

endmodule
